// File: rtl/prv_trap_sequencer.sv
// rtl/prv_trap_sequencer.sv - trap/return sequencer: prioritise, drain pipeline, redirect pc
// Optional vectored interrupt dispatch when PRV_TRAP_VECTORED_EN is defined.
module prv_trap_sequencer #(
  parameter int NUM_EXC       = 16,
  parameter int NUM_INT       = 12,
  parameter int XLEN          = 32,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_EXC-1:0]   exc_vec,
  input  logic [XLEN-1:0]      exc_epc,
  input  logic [XLEN-1:0]      exc_tval,
  input  logic [NUM_INT-1:0]   int_pending,
  input  logic [NUM_INT-1:0]   int_enable,
  input  logic                 global_ie,
  input  logic [XLEN-1:0]      next_pc,
  input  logic                 mret,
  input  logic                 sret,
  input  logic [1:0]           target_lvl,
  input  logic [3:0][XLEN-1:0] xtvec,
  input  logic [3:0][XLEN-1:0] xepc_r,
  input  logic                 pipe_clear,
  output logic                 intr,
  output logic                 insert_pc,
  output logic [XLEN-1:0]      priv_pc,
  output logic                 trap_valid,
  output logic                 trap_is_int,
  output logic [4:0]           trap_cause,
  output logic [XLEN-1:0]      trap_epc,
  output logic [XLEN-1:0]      trap_tval,
  output logic                 ret_valid,
  output logic                 drain_timeout,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, INSERT} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic               ret_flag;
  logic               timeout_hit;
  logic               exc_hit, int_hit;
  logic [4:0]         exc_code, int_code;
  logic [NUM_INT-1:0] int_req;
  logic [XLEN-1:0]    tvec_base, trap_target;

  // Lowest index wins: scan downward so the last match is the smallest.
  always_comb begin
    exc_hit  = |exc_vec;
    exc_code = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--)
      if (exc_vec[i]) exc_code = 5'(i);
    int_req  = int_pending & int_enable;
    int_hit  = global_ie & (|int_req);
    int_code = '0;
    for (int i = NUM_INT - 1; i >= 0; i--)
      if (int_req[i]) int_code = 5'(i);
  end

  always_comb begin
    tvec_base = {xtvec[target_lvl][XLEN-1:2], 2'b00};
`ifdef PRV_TRAP_VECTORED_EN
    if (trap_is_int && (xtvec[target_lvl][1:0] == 2'b01))
      trap_target = tvec_base + (XLEN'(trap_cause) << 2);
    else
      trap_target = tvec_base;
`else
    trap_target = tvec_base;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    intr        = 1'b0;
    insert_pc   = 1'b0;
    trap_valid  = 1'b0;
    ret_valid   = 1'b0;
    priv_pc     = '0;
    timeout_hit = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (exc_hit || int_hit || mret || sret) state_n = DRAIN;
      end
      DRAIN: begin
        intr = 1'b1;
        if (pipe_clear) begin
          state_n = INSERT;
        end else if (cnt == CNT_LAST) begin
          state_n     = INSERT;
          timeout_hit = 1'b1;
        end
      end
      INSERT: begin
        insert_pc = 1'b1;
        state_n   = IDLE;
        if (ret_flag) begin
          ret_valid = 1'b1;
          priv_pc   = xepc_r[target_lvl];
        end else begin
          trap_valid = 1'b1;
          priv_pc    = trap_target;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Cause/epc/tval persist across returns; only a new trap overwrites them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt           <= '0;
      ret_flag      <= 1'b0;
      drain_timeout <= 1'b0;
      trap_is_int   <= 1'b0;
      trap_cause    <= '0;
      trap_epc      <= '0;
      trap_tval     <= '0;
    end else begin
      cnt <= (state == DRAIN) ? cnt + CNT_W'(1) : '0;
      if (timeout_hit) drain_timeout <= 1'b1;
      if (state == IDLE) begin
        if (exc_hit) begin
          ret_flag    <= 1'b0;
          trap_is_int <= 1'b0;
          trap_cause  <= exc_code;
          trap_epc    <= exc_epc;
          trap_tval   <= exc_tval;
        end else if (int_hit) begin
          ret_flag    <= 1'b0;
          trap_is_int <= 1'b1;
          trap_cause  <= int_code;
          trap_epc    <= next_pc;
          trap_tval   <= '0;
        end else if (mret || sret) begin
          ret_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// tb/tb_prv_trap_sequencer.sv - directed self-checking bench for prv_trap_sequencer
module tb_prv_trap_sequencer;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [15:0]      exc_vec = '0;
  logic [31:0]      exc_epc = '0;
  logic [31:0]      exc_tval = '0;
  logic [11:0]      int_pending = '0;
  logic [11:0]      int_enable = '0;
  logic             global_ie = 1'b0;
  logic [31:0]      next_pc = '0;
  logic             mret = 1'b0;
  logic             sret = 1'b0;
  logic [1:0]       target_lvl = 2'd3;
  logic [3:0][31:0] xtvec = '0;
  logic [3:0][31:0] xepc_r = '0;
  logic             pipe_clear = 1'b0;
  logic             intr, insert_pc, trap_valid, trap_is_int, ret_valid, drain_timeout, busy;
  logic [31:0]      priv_pc, trap_epc, trap_tval;
  logic [4:0]       trap_cause;

  int checks = 0;
  int failures = 0;

  prv_trap_sequencer dut (
    .CLK(CLK), .RST(RST), .exc_vec(exc_vec), .exc_epc(exc_epc), .exc_tval(exc_tval),
    .int_pending(int_pending), .int_enable(int_enable), .global_ie(global_ie),
    .next_pc(next_pc), .mret(mret), .sret(sret), .target_lvl(target_lvl),
    .xtvec(xtvec), .xepc_r(xepc_r), .pipe_clear(pipe_clear), .intr(intr),
    .insert_pc(insert_pc), .priv_pc(priv_pc), .trap_valid(trap_valid),
    .trap_is_int(trap_is_int), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .trap_tval(trap_tval), .ret_valid(ret_valid), .drain_timeout(drain_timeout),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic [31:0] exp_vec_pc;
    xtvec[3]  = 32'h8000_1003;
    xepc_r[3] = 32'h8000_0400;
    xepc_r[1] = 32'h0000_1234;

    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_intr", 64'(intr), 64'd0);
    chk("rst_insert", 64'(insert_pc), 64'd0);
    chk("rst_priv_pc", 64'(priv_pc), 64'd0);
    chk("rst_cause", 64'(trap_cause), 64'd0);
    chk("rst_epc", 64'(trap_epc), 64'd0);
    #10 RST = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // Exception, pipe_clear arrives 3 cycles after the request
    exc_vec = 16'h0004; exc_epc = 32'h8000_0100; exc_tval = 32'hDEAD_BEEF;
    tick();
    exc_vec = '0;
    chk("t1_intr", 64'(intr), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    tick();
    chk("t1_still_drain", 64'(intr), 64'd1);
    chk("t1_no_insert", 64'(insert_pc), 64'd0);
    pipe_clear = 1'b1;
    tick();
    pipe_clear = 1'b0;
    chk("t1_insert", 64'(insert_pc), 64'd1);
    chk("t1_intr_low", 64'(intr), 64'd0);
    chk("t1_priv_pc", 64'(priv_pc), 64'h8000_1000);
    chk("t1_trap_valid", 64'(trap_valid), 64'd1);
    chk("t1_ret_valid", 64'(ret_valid), 64'd0);
    chk("t1_cause", 64'(trap_cause), 64'd2);
    chk("t1_epc", 64'(trap_epc), 64'h8000_0100);
    chk("t1_tval", 64'(trap_tval), 64'hDEAD_BEEF);
    chk("t1_is_int", 64'(trap_is_int), 64'd0);
    tick();
    chk("t1_back_idle", 64'(busy), 64'd0);
    chk("t1_insert_one", 64'(insert_pc), 64'd0);
    chk("t1_cause_hold", 64'(trap_cause), 64'd2);

    // Exception beats a simultaneous interrupt; interrupt follows afterwards
    exc_vec = 16'h0024; int_pending = 12'h080; int_enable = 12'h080; global_ie = 1'b1;
    next_pc = 32'h0000_0300; pipe_clear = 1'b1;
    tick();
    exc_vec = '0;
    tick();
    chk("t2_cause", 64'(trap_cause), 64'd2);
    chk("t2_is_int", 64'(trap_is_int), 64'd0);
    chk("t2_insert", 64'(insert_pc), 64'd1);
    tick();
    chk("t2_idle", 64'(busy), 64'd0);
    tick();
    int_pending = '0;
    chk("t2_int_drain", 64'(intr), 64'd1);
    tick();
    chk("t2_int_insert", 64'(insert_pc), 64'd1);
    chk("t2_int_cause", 64'(trap_cause), 64'd7);
    chk("t2_int_is_int", 64'(trap_is_int), 64'd1);
    chk("t2_int_epc", 64'(trap_epc), 64'h300);
    chk("t2_int_tval", 64'(trap_tval), 64'd0);
    chk("t2_int_pc", 64'(priv_pc), 64'h8000_1000);
    tick();

    // Interrupt masked by global_ie
    int_pending = 12'h880; int_enable = 12'h880; global_ie = 1'b0;
    tick();
    chk("t3_masked", 64'(busy), 64'd0);

    // Vectored interrupt: lowest index 7 wins
    global_ie = 1'b1; next_pc = 32'h200; xtvec[3] = 32'h0000_1001;
    tick();
    int_pending = '0;
    tick();
`ifdef PRV_TRAP_VECTORED_EN
    exp_vec_pc = 32'h0000_101C;
`else
    exp_vec_pc = 32'h0000_1000;
`endif
    chk("t3_insert", 64'(insert_pc), 64'd1);
    chk("t3_priv_pc", 64'(priv_pc), 64'(exp_vec_pc));
    chk("t3_cause", 64'(trap_cause), 64'd7);
    chk("t3_epc", 64'(trap_epc), 64'h200);
    tick();

    // mret with pipe_clear already high: insert_pc in the 2nd cycle
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("t4_cyc1_no_insert", 64'(insert_pc), 64'd0);
    tick();
    chk("t4_insert", 64'(insert_pc), 64'd1);
    chk("t4_priv_pc", 64'(priv_pc), 64'h8000_0400);
    chk("t4_ret_valid", 64'(ret_valid), 64'd1);
    chk("t4_trap_valid", 64'(trap_valid), 64'd0);
    chk("t4_cause_hold", 64'(trap_cause), 64'd7);
    tick();

    // sret to level 1
    sret = 1'b1; target_lvl = 2'd1;
    tick();
    sret = 1'b0;
    tick();
    chk("t4s_priv_pc", 64'(priv_pc), 64'h1234);
    chk("t4s_ret_valid", 64'(ret_valid), 64'd1);
    tick();
    target_lvl = 2'd3;

    // Drain timeout
    chk("t5_no_timeout_yet", 64'(drain_timeout), 64'd0);
    pipe_clear = 1'b0; exc_vec = 16'h0001;
    tick();
    exc_vec = '0;
    n = 0;
    while (!insert_pc && n < 200) begin
      tick();
      n++;
    end
    chk("t5_cycles", 64'(n), 64'd64);
    chk("t5_insert", 64'(insert_pc), 64'd1);
    chk("t5_timeout", 64'(drain_timeout), 64'd1);
    chk("t5_cause", 64'(trap_cause), 64'd0);
    tick();
    tick();
    chk("t5_timeout_sticky", 64'(drain_timeout), 64'd1);

    // Asynchronous reset while draining
    exc_vec = 16'h0002;
    tick();
    exc_vec = '0;
    chk("t6_in_drain", 64'(intr), 64'd1);
    #2 RST = 1'b1;
    #1;
    chk("t6_intr_async", 64'(intr), 64'd0);
    chk("t6_busy_async", 64'(busy), 64'd0);
    chk("t6_insert_async", 64'(insert_pc), 64'd0);
    chk("t6_timeout_clr", 64'(drain_timeout), 64'd0);
    chk("t6_cause_clr", 64'(trap_cause), 64'd0);
    #3 RST = 1'b0;
    tick();
    chk("t6_idle_after", 64'(busy), 64'd0);
    chk("t6_pc_after", 64'(priv_pc), 64'd0);
    chk("t6_epc_after", 64'(trap_epc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prv_trap_sequencer.md
Name: prv_trap_sequencer

Overview:
- Parametrised trap/return sequencer between the pipeline hazard unit and the privilege block.
- Collects exception causes from N sources and interrupt pending bits from M sources, and prioritises them.
- Drains the pipeline via an intr/pipe_clear handshake, then drives insert_pc/priv_pc for exactly one cycle.
- Generalises the fixed exception signal set to parametrised cause vectors, and adds mret/sret return sequencing plus a drain timeout.

Parameters:
- NUM_EXC, 16, number of synchronous exception sources; index equals mcause exception code.
- NUM_INT, 12, number of interrupt sources; index equals mcause interrupt code.
- XLEN, 32, datapath width.
- DRAIN_TIMEOUT, 64, maximum cycles spent in DRAIN waiting for pipe_clear.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- exc_vec  in  NUM_EXC  one-hot-or-more exception requests from the oldest instruction
- exc_epc  in  XLEN  pc of the faulting instruction
- exc_tval  in  XLEN  bad address/instruction for the exception
- int_pending  in  NUM_INT  interrupt pending bits
- int_enable  in  NUM_INT  interrupt enable bits (mie)
- global_ie  in  1  mstatus.MIE for the current privilege level
- next_pc  in  XLEN  pc to save as epc when taking an interrupt
- mret, sret  in  1 each  return instruction committing
- target_lvl  in  2  privilege level of the trap handler; indexes xtvec/xepc_r
- xtvec  in  4 x XLEN  trap vector per privilege level
- xepc_r  in  4 x XLEN  saved epc per privilege level
- pipe_clear  in  1  pipeline fully drained
- intr  out  1  request pipeline flush/drain
- insert_pc  out  1  one-cycle redirect strobe
- priv_pc  out  XLEN  redirect target
- trap_valid  out  1  one-cycle strobe: CSR block commits cause/epc/tval
- trap_is_int  out  1  latched cause is an interrupt
- trap_cause  out  5  latched cause code
- trap_epc  out  XLEN  latched epc
- trap_tval  out  XLEN  latched tval (0 for interrupts)
- ret_valid  out  1  one-cycle strobe: return committed
- drain_timeout  out  1  sticky flag, set when DRAIN expired; cleared only by reset
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, active-high, valid mid-operation):
  - FSM goes to IDLE; timeout counter is 0.
  - All outputs are 0; latched cause/epc/tval are 0.
- States: IDLE, DRAIN, INSERT.
- Priority is evaluated in IDLE only:
  - Any exc_vec bit beats interrupts, which beat mret, which beats sret.
  - Among exceptions and among interrupts, the lowest index wins.
  - Interrupt eligibility: global_ie & |(int_pending & int_enable).
- IDLE -> DRAIN (next edge) on any qualified event:
  - Exception: latch cause=index, epc=exc_epc, tval=exc_tval, is_int=0.
  - Interrupt: latch cause=index, epc=next_pc, tval=0, is_int=1.
  - Return: latch a ret flag (mret or sret).
- DRAIN:
  - intr=1 and busy=1; the counter increments every cycle.
  - Advance to INSERT when pipe_clear=1, or when counter == DRAIN_TIMEOUT-1 (this also sets drain_timeout).
  - All new requests are ignored (sources hold them).
- INSERT, exactly one cycle, then back to IDLE with the counter cleared:
  - insert_pc=1 and intr=0.
  - Trap: priv_pc = {xtvec[target_lvl][XLEN-1:2], 2'b00}, trap_valid=1.
  - Return: priv_pc = xepc_r[target_lvl], ret_valid=1.
- Latency from event to insert_pc is pipe_clear arrival + 1 cycle; the minimum is 2 cycles if pipe_clear is already high.
- target_lvl and xtvec are sampled in INSERT; they must be stable from DRAIN onward.
- trap_cause/epc/tval/is_int hold their value until the next trap is latched.
- Widths: cause indices above 31 are truncated to 5 bits; NUM_EXC and NUM_INT are each required to be ≤ 32.

Optional Feature:
- Macro: PRV_TRAP_VECTORED_EN.
- With the macro defined, an interrupt trap where xtvec[target_lvl][1:0]==2'b01 uses priv_pc = base + 4*cause, wrapping modulo 2^XLEN. Exceptions always use the base.
- Without the macro, mode bits are ignored and every trap uses the base (direct mode only).

Test Plan:
- exc_vec=0x0004, exc_epc=0x80000100, exc_tval=0xDEADBEEF, pipe_clear high 3 cycles later:
  - insert_pc one cycle after pipe_clear; priv_pc=xtvec[3]&~3.
  - trap_cause=2, trap_epc=0x80000100, trap_tval=0xDEADBEEF, trap_is_int=0.
- exc_vec=0x0024 together with int_pending=int_enable=0x080, global_ie=1 -> cause=2, trap_is_int=0; the interrupt is taken afterwards only if still pending.
- int_pending=0x880, int_enable=0x880, global_ie=1, next_pc=0x200, xtvec[3]=0x1001:
  - Macro defined: priv_pc=0x101C, cause=7.
  - Macro undefined: priv_pc=0x1000.
- mret=1, xepc_r[3]=0x80000400, pipe_clear already 1 -> insert_pc in the 2nd cycle, priv_pc=0x80000400, ret_valid=1, trap_valid=0.
- Exception with pipe_clear held 0 -> insert_pc exactly DRAIN_TIMEOUT cycles after entering DRAIN; drain_timeout=1 and remains set.
- RST asserted in DRAIN -> intr, busy and insert_pc drop asynchronously; after release, FSM is IDLE and outputs are 0.
